// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: default timing parameters and
// the 2-bit FSM state encoding that is common to the transmitter.
package uart_rx_pkg;

   localparam int CLKS_PER_BIT_DEF = 1085;
   localparam int DATA_BITS_DEF    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } rxState_e;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver output bundle: received byte plus its valid/frame-error strobes
// and the busy indication. The receiver drives it, the consumer reads it.
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);

   logic [DATA_BITS-1:0] o_data;
   logic                 o_valid;
   logic                 o_frame_err;
   logic                 o_busy;

   modport master (
      output o_data,
      output o_valid,
      output o_frame_err,
      output o_busy
   );

   modport slave (
      input o_data,
      input o_valid,
      input o_frame_err,
      input o_busy
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input. The reset value
// is a parameter so an idle-high line does not look like an edge after reset.
module uart_rx_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line. Samples each bit at its
// centre and strobes o_valid or o_frame_err for one cycle per frame.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int DATA_BITS    = DATA_BITS_DEF
) (
   input  logic      sysclk,
   input  logic      rst,
   input  logic      i_en,
   input  logic      i_rx,
   uart_rx_if.master rxIf
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   logic                 rxSync;
   rxState_e             state_q;
   logic [CW-1:0]        clkCnt_q;
   logic [IW-1:0]        bitIdx_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] shift_d;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 frameErr_q;

   uart_rx_sync #(
      .RESET_VAL (1'b1)
   ) uSync (
      .clk (sysclk),
      .rst (rst),
      .d_i (i_rx),
      .q_o (rxSync)
   );

   always_comb begin
      shift_d           = shift_q;
      shift_d[bitIdx_q] = rxSync;
   end

   // Leaving STOP at mid stop bit leaves half a bit to catch a back-to-back start edge.
   always_ff @(posedge sysclk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         clkCnt_q   <= '0;
         bitIdx_q   <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
      end else begin
         valid_q    <= 1'b0;
         frameErr_q <= 1'b0;
         if (!i_en) begin
            state_q  <= IDLE;
            clkCnt_q <= '0;
            bitIdx_q <= '0;
         end else begin
            case (state_q)
               IDLE: begin
                  clkCnt_q <= '0;
                  bitIdx_q <= '0;
                  if (!rxSync) begin
                     state_q <= START;
                  end
               end
               START: begin
                  if (clkCnt_q == HALF_LAST) begin
                     clkCnt_q <= '0;
                     bitIdx_q <= '0;
                     state_q  <= rxSync ? IDLE : DATA;
                  end else begin
                     clkCnt_q <= clkCnt_q + 1'b1;
                  end
               end
               DATA: begin
                  if (clkCnt_q == BIT_LAST) begin
                     clkCnt_q <= '0;
                     shift_q  <= shift_d;
                     if (bitIdx_q == IDX_LAST) begin
                        bitIdx_q <= '0;
                        state_q  <= STOP;
                     end else begin
                        bitIdx_q <= bitIdx_q + 1'b1;
                     end
                  end else begin
                     clkCnt_q <= clkCnt_q + 1'b1;
                  end
               end
               STOP: begin
                  if (clkCnt_q == BIT_LAST) begin
                     clkCnt_q   <= '0;
                     data_q     <= shift_q;
                     valid_q    <= rxSync;
                     frameErr_q <= !rxSync;
                     state_q    <= IDLE;
                  end else begin
                     clkCnt_q <= clkCnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign rxIf.o_data      = data_q;
   assign rxIf.o_valid     = valid_q;
   assign rxIf.o_frame_err = frameErr_q;
   assign rxIf.o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 clocks per bit: a table of frames
// followed by hand-written back-to-back, glitch, enable, reset and break cases.
module tb_uart_rx;

   localparam int CPB = 16;

   logic sysclk = 1'b0;
   logic rst;
   logic iEn;
   logic iRx;

   uart_rx_if #(.DATA_BITS(8)) rxIf ();

   uart_rx #(
      .CLKS_PER_BIT (CPB),
      .DATA_BITS    (8)
   ) dut (
      .sysclk (sysclk),
      .rst    (rst),
      .i_en   (iEn),
      .i_rx   (iRx),
      .rxIf   (rxIf)
   );

   always #5 sysclk = ~sysclk;

   typedef struct {
      int         cyc;
      logic [7:0] data;
      logic       v;
      logic       e;
   } strobe_t;

   typedef struct {
      logic [7:0] b;
      logic       stopBit;
      logic [7:0] expData;
      logic       expV;
      logic       expE;
   } vector_t;

   int      cycle = 0;
   int      startCycle;
   int      testsRun = 0;
   int      testsFailed = 0;
   strobe_t events[$];
   vector_t vectors[6];

   always @(posedge sysclk) cycle <= cycle + 1;

   // Every cycle a strobe is seen becomes one event, so a stretched pulse shows up as extra events.
   always @(negedge sysclk) begin
      if (!rst && (rxIf.o_valid || rxIf.o_frame_err)) begin
         strobe_t ev;
         ev.cyc  = cycle;
         ev.data = rxIf.o_data;
         ev.v    = rxIf.o_valid;
         ev.e    = rxIf.o_frame_err;
         events.push_back(ev);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge sysclk);
      #1;
   endtask

   task automatic applyStimulus(input logic [7:0] b, input logic stopBit);
      iRx = 1'b0;
      startCycle = cycle;
      waitCycles(CPB);
      for (int i = 0; i < 8; i++) begin
         iRx = b[i];
         waitCycles(CPB);
      end
      iRx = stopBit;
      waitCycles(CPB);
      iRx = 1'b1;
   endtask

   task automatic checkSingle(input string name, input logic [7:0] expData,
                              input logic expV, input logic expE);
      strobe_t ev;
      checkOutput({name, " strobe count"}, events.size(), 1);
      if (events.size() >= 1) begin
         ev = events.pop_front();
         checkOutput({name, " data"}, ev.data, expData);
         checkOutput({name, " valid"}, ev.v, expV);
         checkOutput({name, " frame_err"}, ev.e, expE);
         checkOutput({name, " latency"}, ev.cyc - startCycle - 1, 154);
      end
      events.delete();
   endtask

   initial begin
      strobe_t evA;
      strobe_t evB;

      vectors[0] = '{8'hA5, 1'b1, 8'hA5, 1'b1, 1'b0};
      vectors[1] = '{8'h55, 1'b0, 8'h55, 1'b0, 1'b1};
      vectors[2] = '{8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
      vectors[3] = '{8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vectors[4] = '{8'h3C, 1'b1, 8'h3C, 1'b1, 1'b0};
      vectors[5] = '{8'h81, 1'b0, 8'h81, 1'b0, 1'b1};

      rst = 1'b1;
      iEn = 1'b1;
      iRx = 1'b1;
      waitCycles(3);
      rst = 1'b0;
      waitCycles(3);
      checkOutput("reset data", rxIf.o_data, 8'h00);
      checkOutput("reset valid", rxIf.o_valid, 1'b0);
      checkOutput("reset frame_err", rxIf.o_frame_err, 1'b0);
      checkOutput("reset busy", rxIf.o_busy, 1'b0);

      for (int i = 0; i < 6; i++) begin
         events.delete();
         applyStimulus(vectors[i].b, vectors[i].stopBit);
         waitCycles(20);
         checkSingle($sformatf("vector%0d", i), vectors[i].expData,
                     vectors[i].expV, vectors[i].expE);
      end

      events.delete();
      applyStimulus(8'h3C, 1'b1);
      applyStimulus(8'hFF, 1'b1);
      waitCycles(20);
      checkOutput("b2b strobe count", events.size(), 2);
      if (events.size() >= 2) begin
         evA = events.pop_front();
         evB = events.pop_front();
         checkOutput("b2b first data", evA.data, 8'h3C);
         checkOutput("b2b second data", evB.data, 8'hFF);
         checkOutput("b2b both valid", {evA.v, evA.e, evB.v, evB.e}, 4'b1010);
         checkOutput("b2b spacing", evB.cyc - evA.cyc, 160);
      end
      checkOutput("b2b data held", rxIf.o_data, 8'hFF);

      events.delete();
      iRx = 1'b0;
      waitCycles(4);
      iRx = 1'b1;
      checkOutput("glitch busy during start", rxIf.o_busy, 1'b1);
      waitCycles(8);
      checkOutput("glitch busy dropped", rxIf.o_busy, 1'b0);
      waitCycles(20);
      checkOutput("glitch no strobe", events.size(), 0);

      events.delete();
      fork
         applyStimulus(8'h81, 1'b1);
         begin
            waitCycles(CPB * 4 + 8);
            iEn = 1'b0;
            waitCycles(1);
            checkOutput("disable busy", rxIf.o_busy, 1'b0);
            checkOutput("disable data retained", rxIf.o_data, 8'hFF);
         end
      join
      waitCycles(5);
      iEn = 1'b1;
      waitCycles(5);
      checkOutput("disabled frame no strobe", events.size(), 0);
      applyStimulus(8'h81, 1'b1);
      waitCycles(20);
      checkSingle("reenable", 8'h81, 1'b1, 1'b0);

      events.delete();
      fork
         applyStimulus(8'hF0, 1'b1);
         begin
            waitCycles(CPB * 6 + 8);
            rst = 1'b1;
            #1;
            checkOutput("midframe rst outputs",
                        {rxIf.o_data, rxIf.o_valid, rxIf.o_frame_err, rxIf.o_busy}, 11'h0);
            waitCycles(2);
            rst = 1'b0;
         end
      join
      waitCycles(20);
      checkOutput("rst frame no strobe", events.size(), 0);
      applyStimulus(8'h12, 1'b1);
      waitCycles(20);
      checkSingle("after rst", 8'h12, 1'b1, 1'b0);

      events.delete();
      iRx = 1'b0;
      waitCycles(160);
      checkOutput("break restarts frame", rxIf.o_busy, 1'b1);
      iRx = 1'b1;
      waitCycles(40);
      checkOutput("break strobe count", events.size(), 1);
      if (events.size() >= 1) begin
         evA = events.pop_front();
         checkOutput("break data", evA.data, 8'h00);
         checkOutput("break flags", {evA.v, evA.e}, 2'b01);
      end
      checkOutput("break idle after release", rxIf.o_busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
